// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects A, B and opcode bytes from a UART, runs the ALU for one cycle and transmits the result.
module uart_alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [NB_DATA-1:0] data_a_q, data_b_q, tx_data_q;
    logic [NB_OP-1:0]   op_q;
    logic               valid_q, tx_start_q, timeout;
    assign timeout    = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign o_data_a   = data_a_q;
    assign o_data_b   = data_b_q;
    assign o_op       = op_q;
    assign o_valid    = valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = state_q inside {EXEC, SEND, WAIT_TX};
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state_q    <= WAIT_A;
            cnt_q      <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            valid_q    <= 1'b0;
            tx_start_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_A: if (i_rx_done) begin
                    data_a_q <= i_rx_data;
                    cnt_q    <= '0;
                    state_q  <= WAIT_B;
                end
                WAIT_B: if (i_rx_done) begin
                    data_b_q <= i_rx_data;
                    cnt_q    <= '0;
                    state_q  <= WAIT_OP;
                end else if (timeout) state_q <= WAIT_A;
                else cnt_q <= cnt_q + 1'b1;
                WAIT_OP: if (i_rx_done) begin
                    op_q    <= i_rx_data[NB_OP-1:0];
                    valid_q <= 1'b1;
                    state_q <= EXEC;
                end else if (timeout) state_q <= WAIT_A;
                else cnt_q <= cnt_q + 1'b1;
                EXEC: begin
                    tx_data_q  <= i_alu_result;
                    valid_q    <= 1'b0;
                    tx_start_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    tx_start_q <= 1'b0;
                    state_q    <= WAIT_TX;
                end
                WAIT_TX: if (i_tx_done) state_q <= WAIT_A;
                default: state_q <= WAIT_A;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: directed frame vectors plus timeout, ignore and reset sequences.
module tb_uart_alu_interface;
    logic       clk = 0, i_rst = 0, i_rx_done = 0, i_tx_done = 0;
    logic [7:0] i_rx_data = 0, i_alu_result;
    logic [7:0] o_data_a, o_data_b, o_tx_data;
    logic [5:0] o_op;
    logic       o_valid, o_tx_start, o_busy;
    int total = 0, bad = 0;

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT(16)) dut (
        .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op), .o_valid(o_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // External ALU model: 0x20 ADD, 0x22 SUB, 0x23 OR, 0x24 AND.
    always_comb
        i_alu_result = o_op == 6'h20 ? o_data_a + o_data_b :
                       o_op == 6'h22 ? o_data_a - o_data_b :
                       o_op == 6'h23 ? o_data_a | o_data_b :
                       o_op == 6'h24 ? o_data_a & o_data_b : 8'h00;

    typedef struct {
        logic [7:0] a, b, op_byte, exp_res;
        logic [5:0] exp_op;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1;
        tick(1);
        i_rx_done = 0;
    endtask

    task automatic tx_done_pulse();
        i_tx_done = 1;
        tick(1);
        i_tx_done = 0;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_a"}, o_data_a, 0);
        chk({name, "_b"}, o_data_b, 0);
        chk({name, "_op"}, o_op, 0);
        chk({name, "_txd"}, o_tx_data, 0);
        chk({name, "_ctl"}, {o_valid, o_tx_start, o_busy}, 0);
    endtask

    // Op byte accepted at the last tick: valid at k+1, tx_start at k+2, then WAIT_TX.
    task automatic check_exec(input string name, input logic [7:0] exp_res);
        chk({name, "_k1"}, {o_valid, o_tx_start, o_busy}, 3'b101);
        tick(1);
        chk({name, "_k2"}, {o_valid, o_tx_start, o_busy}, 3'b011);
        chk({name, "_txd"}, o_tx_data, exp_res);
        tick(1);
        chk({name, "_k3"}, {o_valid, o_tx_start, o_busy}, 3'b001);
    endtask

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, op_byte: 8'h20, exp_res: 8'h08, exp_op: 6'b100000};
        vecs[1] = '{a: 8'h0A, b: 8'h02, op_byte: 8'h22, exp_res: 8'h08, exp_op: 6'h22};
        vecs[2] = '{a: 8'hFF, b: 8'h01, op_byte: 8'h20, exp_res: 8'h00, exp_op: 6'h20};
        vecs[3] = '{a: 8'h07, b: 8'h09, op_byte: 8'hE3, exp_res: 8'h0F, exp_op: 6'b100011};
        vecs[4] = '{a: 8'hF0, b: 8'h3C, op_byte: 8'h64, exp_res: 8'h30, exp_op: 6'h24};

        tick(2);
        check_zero("reset");
        i_rst = 1;
        tick(1);

        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            send_byte(vecs[i].op_byte);
            chk($sformatf("v%0d_a", i), o_data_a, vecs[i].a);
            chk($sformatf("v%0d_b", i), o_data_b, vecs[i].b);
            chk($sformatf("v%0d_op", i), o_op, vecs[i].exp_op);
            check_exec($sformatf("v%0d", i), vecs[i].exp_res);
            tx_done_pulse();
            chk($sformatf("v%0d_idle", i), o_busy, 0);
            chk($sformatf("v%0d_hold", i), o_op, vecs[i].exp_op);
        end

        // Stray tx_done in WAIT_A is ignored; then timeout after 16 idle cycles in WAIT_B.
        tx_done_pulse();
        chk("stray_txdone", o_busy, 0);
        send_byte(8'h11);
        tick(16);
        send_byte(8'h0A);
        send_byte(8'h02);
        send_byte(8'h22);
        chk("to_a", o_data_a, 8'h0A);
        chk("to_b", o_data_b, 8'h02);
        check_exec("to", 8'h08);
        tx_done_pulse();

        // Byte arriving exactly in the timeout cycle is still accepted.
        send_byte(8'h11);
        tick(15);
        send_byte(8'h22);
        send_byte(8'h20);
        chk("edge_b", o_data_b, 8'h22);
        check_exec("edge", 8'h33);

        // rx_done during WAIT_TX is ignored.
        send_byte(8'h77);
        chk("ign_a", o_data_a, 8'h11);
        chk("ign_busy", o_busy, 1);
        tx_done_pulse();
        send_byte(8'h04);
        send_byte(8'h06);
        send_byte(8'h20);
        chk("post_ign_a", o_data_a, 8'h04);
        check_exec("post_ign", 8'h0A);
        tx_done_pulse();

        // Reset mid-frame clears everything; next byte becomes A.
        send_byte(8'h12);
        send_byte(8'h34);
        i_rst = 0;
        tick(1);
        check_zero("midrst");
        i_rst = 1;
        tick(1);
        send_byte(8'h56);
        chk("rst_new_a", o_data_a, 8'h56);
        chk("rst_new_b", o_data_b, 8'h00);
        chk("rst_new_busy", o_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_alu_interface.md
UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 Parameter NB_DATA, default 8, SHALL set the width of operand, result and UART byte paths.
REQ-002 Parameter NB_OP, default 6, SHALL set the opcode width.
REQ-003 Parameter TIMEOUT, default 1024, SHALL set the inter-byte timeout in clk cycles; 0 disables the timeout.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  SHALL be the reset, synchronous and active-low.
REQ-006 i_rx_data  input  NB_DATA  SHALL carry the received UART byte, valid when i_rx_done=1.
REQ-007 i_rx_done  input  1  SHALL be a one-cycle pulse marking a received byte.
REQ-008 i_alu_result  input  NB_DATA  SHALL carry the combinational ALU result for the presented operands.
REQ-009 i_tx_done  input  1  SHALL be a one-cycle pulse marking completion of a UART transmit.
REQ-010 o_data_a  output  NB_DATA  SHALL drive ALU operand A.
REQ-011 o_data_b  output  NB_DATA  SHALL drive ALU operand B.
REQ-012 o_op  output  NB_OP  SHALL drive the ALU opcode.
REQ-013 o_valid  output  1  SHALL drive the ALU valid input.
REQ-014 o_tx_data  output  NB_DATA  SHALL carry the byte to transmit.
REQ-015 o_tx_start  output  1  SHALL be a one-cycle transmit request pulse.
REQ-016 o_busy  output  1  SHALL be 1 in states EXEC, SEND, WAIT_TX, else 0.

Function
REQ-017 FSM states SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX; all outputs registered except o_busy (decoded from state).
REQ-018 WAIT_A + i_rx_done: o_data_a <= i_rx_data, go WAIT_B.
REQ-019 WAIT_B + i_rx_done: o_data_b <= i_rx_data, go WAIT_OP.
REQ-020 WAIT_OP + i_rx_done: o_op <= i_rx_data[NB_OP-1:0] (upper bits discarded), o_valid <= 1, go EXEC.
REQ-021 EXEC SHALL last exactly one cycle: o_valid high during it, o_tx_data <= i_alu_result at its end, o_valid <= 0, o_tx_start <= 1, go SEND.
REQ-022 SEND SHALL last exactly one cycle with o_tx_start=1, then o_tx_start <= 0, go WAIT_TX.
REQ-023 WAIT_TX SHALL hold until i_tx_done, then go WAIT_A.
REQ-024 Latency: op byte i_rx_done at cycle k -> o_valid high at k+1 only, o_tx_start high at k+2 only.
REQ-025 i_rx_done in EXEC, SEND or WAIT_TX SHALL be ignored; no register changes.
REQ-026 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-027 Timeout counter SHALL clear on entry to WAIT_B/WAIT_OP and increment each cycle in those states without i_rx_done.
REQ-028 If TIMEOUT>0 and the counter equals TIMEOUT-1 with no i_rx_done, the FSM SHALL go WAIT_A next cycle; o_data_a/o_data_b retain values and are overwritten by the next frame.
REQ-029 i_rx_done in the timeout cycle SHALL win: the byte is accepted, no timeout.
REQ-030 o_data_a, o_data_b, o_op SHALL hold until overwritten by a new frame.

Reset
REQ-031 i_rst=0 at a rising edge SHALL force WAIT_A, clear the timeout counter and drive o_data_a, o_data_b, o_op, o_tx_data to 0 and o_valid, o_tx_start, o_busy to 0, from any state including mid-frame and WAIT_TX.
REQ-032 The first i_rx_done after reset release SHALL be treated as operand A.

Verification
REQ-033 Reset: i_rst=0 for 2 cycles -> all outputs 0, o_busy=0.
REQ-034 Frame 0x05,0x03,0x20 with ALU model ADD -> o_data_a=0x05, o_data_b=0x03, o_op=6'b100000, o_valid one cycle at k+1, o_tx_data=0x08, o_tx_start one cycle at k+2; after i_tx_done, o_busy=0.
REQ-035 TIMEOUT=16: byte 0x11 then 16 idle cycles -> back in WAIT_A; frame 0x0A,0x02,0x22 (SUB) -> o_data_a=0x0A, o_tx_data=0x08.
REQ-036 i_rx_done with 0x77 during WAIT_TX -> ignored, o_data_a unchanged; next frame processed normally.
REQ-037 Op byte 0xE3 -> o_op=6'b100011.
REQ-038 i_rst=0 after bytes A=0x12, B=0x34 -> all outputs 0; next byte 0x56 captured as o_data_a.
